// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder.
// Holds segment patterns, code constants and the scan FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    localparam logic [3:0] CODE_DASH = 4'hA;
    localparam logic [3:0] CODE_ERR  = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to digit-code decoder.
// Define SEG7_DASH_EN to accept the dash pattern as code 4'hA.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       valid
);

    always_comb begin
        code  = CODE_ERR;
        valid = 1'b0;
        case (seg)
            SEG_0: begin code = 4'd0; valid = 1'b1; end
            SEG_1: begin code = 4'd1; valid = 1'b1; end
            SEG_2: begin code = 4'd2; valid = 1'b1; end
            SEG_3: begin code = 4'd3; valid = 1'b1; end
            SEG_4: begin code = 4'd4; valid = 1'b1; end
            SEG_5: begin code = 4'd5; valid = 1'b1; end
            SEG_6: begin code = 4'd6; valid = 1'b1; end
            SEG_7: begin code = 4'd7; valid = 1'b1; end
            SEG_8: begin code = 4'd8; valid = 1'b1; end
            SEG_9: begin code = 4'd9; valid = 1'b1; end
`ifdef SEG7_DASH_EN
            SEG_DASH: begin code = CODE_DASH; valid = 1'b1; end
`else
            SEG_DASH: begin code = CODE_ERR; valid = 1'b0; end
`endif
            default: begin code = CODE_ERR; valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment display and rebuilds whole frames.
// Dash support is selected by the SEG7_DASH_EN macro (in the decoder).
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    frame_err,
    output logic                    overrun
);
    import seg7_pkg::*;

    localparam int SW = NUM_DIGITS + 7;
    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [SW-1:0]           prev_q, prev_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [NUM_DIGITS-1:0]   errb_q, errb_d;
    logic [4*NUM_DIGITS-1:0] stage_q, stage_d;
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;

    logic [SW-1:0] sample;
    logic          onehot;
    logic          changed;
    logic          capture;
    logic          complete;
    logic [3:0]    dec_code;
    logic          dec_valid;

    assign sample  = {an, seg};
    assign onehot  = $onehot(an);
    assign changed = (sample != prev_q);

    seg7_pattern_decode u_dec (
        .seg   (seg),
        .code  (dec_code),
        .valid (dec_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = sample;
        mask_d   = mask_q;
        errb_d   = errb_q;
        stage_d  = stage_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = ferr_q;
        ovr_d    = 1'b0;
        capture  = 1'b0;
        complete = 1'b0;

        if (!onehot) begin
            state_d = ST_WAIT;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                ST_WAIT, ST_HOLD: begin
                    if (changed) begin
                        state_d = ST_SETTLE;
                        cnt_d   = 4'd1;
                    end
                end
                ST_SETTLE: begin
                    cnt_d = changed ? 4'd1 : cnt_q + 4'd1;
                end
                default: begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'd0;
                end
            endcase
            if (state_d == ST_SETTLE && cnt_d == STABLE_N) begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end
        end

        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (an[i]) begin
                    stage_d[4*i +: 4] = dec_code;
                    mask_d[i]         = 1'b1;
                    errb_d[i]         = ~dec_valid;
                end
            end
            complete = &mask_d;
        end

        // A finished frame is dropped if the held one is still unread.
        if (complete) begin
            if (!valid_q || frame_ready) begin
                data_d  = stage_d;
                ferr_d  = |errb_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
            mask_d = '0;
            errb_d = '0;
        end else if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= 4'd0;
            prev_q  <= '0;
            mask_q  <= '0;
            errb_q  <= '0;
            stage_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            errb_q  <= errb_d;
            stage_q <= stage_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign frame_err   = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digit positions.
REQ-002 SHALL have parameter STABLE_CYCLES, default 3: consecutive identical samples (range 1..15) required before a digit is captured.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port seg, input, 7 bits: segment pattern, active-high, bit6=a … bit0=g.
REQ-006 SHALL have port an, input, NUM_DIGITS bits: digit strobe, active-high, one-hot when valid; bit0 = rightmost digit.
REQ-007 SHALL have port frame_data, output, 4*NUM_DIGITS bits: decoded codes, digit i in bits [4i+3:4i].
REQ-008 SHALL have port frame_valid, output, 1 bit: frame_data holds a complete frame.
REQ-009 SHALL have port frame_ready, input, 1 bit: consumer accepts the frame.
REQ-010 SHALL have port frame_err, output, 1 bit: at least one digit in the held frame was undecodable; meaningful only while frame_valid is high.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-012 SHALL decode patterns as follows: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9; any other pattern = code 4'hF, marked invalid.
REQ-013 SHALL use a three-state FSM: WAIT (an not one-hot), SETTLE (counting stable samples), HOLD (digit captured, waiting for change).
REQ-014 SHALL, in any state, transition to WAIT when an is not one-hot, and clear the stability counter.
REQ-015 SHALL, in WAIT or HOLD, move to SETTLE with counter=1 when an is one-hot and {an,seg} differs from the previous-cycle sample.
REQ-016 SHALL, in SETTLE, increment the counter while {an,seg} is unchanged, and restart at 1 on any change.
REQ-017 SHALL, when the counter reaches STABLE_CYCLES, write the decoded code into the staging slot of the strobed digit, set that digit's captured bit and error bit, and enter HOLD in the same cycle.
REQ-018 SHALL, with STABLE_CYCLES=1, capture on the first one-hot cycle following a change.
REQ-019 SHALL let a recapture of an already-captured digit within the same frame overwrite that digit's slot.
REQ-020 SHALL, in the cycle the captured mask becomes all-ones, transfer staging to frame_data, set frame_err to the OR of the error bits, clear the mask, and assert frame_valid on the next cycle.
REQ-021 SHALL hold frame_valid, frame_data and frame_err stable until a cycle with frame_valid && frame_ready, after which frame_valid deasserts.
REQ-022 SHALL, when a frame completes while frame_valid && !frame_ready, drop the new frame, keep the held frame, and pulse overrun.
REQ-023 SHALL, when completion coincides with acceptance (frame_valid && frame_ready), load the new frame and keep frame_valid high.
REQ-024 SHALL have a capture latency of STABLE_CYCLES cycles from the first stable sample to the captured-mask update.

Reset
REQ-025 SHALL, while rst_n is low, force FSM=WAIT, counter=0, mask=0, staging=0, frame_data=0, frame_valid=0, frame_err=0, overrun=0 and the previous-sample register=0.
REQ-026 SHALL, on reset asserted mid-frame, discard the partial frame and any pending frame.

Configuration
REQ-027 SHALL, with SEG7_DASH_EN defined, decode pattern 0000001 to code 4'hA as a valid digit.
REQ-028 SHALL, without SEG7_DASH_EN, treat pattern 0000001 as invalid (code 4'hF, error bit set).

Structure
REQ-029 SHALL place the ten segment-pattern constants, the dash pattern, code constants 4'hA/4'hF and the FSM state enum in the shared package seg7_pkg.
REQ-030 SHALL implement pattern-to-code decoding in a combinational sub-module seg7_pattern_decode (outputs: code, valid).

Verification
REQ-031 SHALL verify, with defaults: scan digits 3,2,1,0 showing 1,2,3,4 for 3 cycles each -> frame_valid with frame_data=16'h1234, frame_err=0.
REQ-032 SHALL verify a 2-cycle glitch of an=4'b0010 with seg=1111111 then the normal scan -> glitch is ignored and digit1 holds the later stable value.
REQ-033 SHALL verify that pattern 0000001 on digit0 -> frame_data[3:0]=4'hA with frame_err=0 under SEG7_DASH_EN, and 4'hF with frame_err=1 without it.
REQ-034 SHALL verify that with frame_ready held low over two complete frames -> the first frame is retained and overrun pulses for exactly 1 cycle.
REQ-035 SHALL verify that rst_n asserted after two digits are captured, then a full scan -> frame_valid is asserted only after all 4 digits are recaptured.
